mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle control unit for the 32-bit ARM-subset core; it drives the datapath's control inputs.
//  Decodes Instr[31:12], sequences each instruction through a Moore FSM and holds the NZCV flags.
//  Evaluates the condition field and stalls on instruction/data memory through a ready handshake.
// PARAMETERS
//  FLAGS_RESET  4'b0000  NZCV value loaded on reset ({N,Z,C,V}, N is bit 3).
//  MEM_WAIT_EN  1        1: honour MemReady. 0: treat MemReady as constant 1.
// PORTS
//  clk         in   1   core clock. All state updates on the rising edge.
//  reset       in   1   synchronous, active-high.
//  Instr       in   20  Instr[31:12] from the IR: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
//  ALUFlags    in   4   {N,Z,C,V} from the ALU in the current cycle.
//  MemReady    in   1   memory has completed the current access this cycle.
//  PCWrite     out  1   load PC from Result.
//  AdrSrc      out  1   0: memory address = PC. 1: memory address = ALUOut.
//  MemWrite    out  1   data memory write strobe.
//  IRWrite     out  1   load IR from ReadData.
//  ResultSrc   out  2   00: ALUOut. 01: Data. 10: ALUResult.
//  ALUSrcA     out  1   0: SrcA = RD1. 1: SrcA = PC.
//  ALUSrcB     out  2   00: WriteData. 01: ExtImm. 10: constant 4.
//  ALUControl  out  2   00: ADD. 01: SUB. 10: AND. 11: ORR.
//  ImmSrc      out  2   equals op (00: 8-bit DP imm, 01: 12-bit mem offset, 10: 24-bit branch).
//  RegSrc      out  2   [0]: op==10 (branch, RA1 = R15). [1]: op==01 (store, RA2 = Rd).
//  RegWrite    out  1   register file write enable.
//  Undef       out  1   one-cycle pulse when op==11 is decoded.
// BEHAVIOUR
//  Reset: state=FETCH, flags=FLAGS_RESET. Every strobe (PCWrite, MemWrite, IRWrite, RegWrite, Undef) is 0
//  in the reset cycle. Other outputs take their FETCH values once reset is released.
//  Outputs are pure Moore decode of state plus the latched Instr. Strobes are never asserted while reset=1.
//  Reset mid-instruction aborts it: no RegWrite, no MemWrite and no flag update on the reset edge.
//  Each state lists its outputs, then its next state:
//  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
//    IRWrite and PCWrite equal MemReady. Next state: DECODE if MemReady, else stay.
//  DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). CondEx is evaluated from the flags register.
//    !CondEx -> FETCH (instruction squashed, no writes).
//    op==11 -> Undef=1, then FETCH.
//    op==00 -> EXECI if funct[5], else EXECR.
//    op==01 -> MEMADR.
//    op==10 -> BRANCH.
//  MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next: MEMRD if funct[0] (L), else MEMWR.
//  MEMRD: AdrSrc=1. The datapath captures ReadData every cycle. Next: MEMWB on MemReady, else stay.
//  MEMWB: ResultSrc=01, RegWrite=1. PCWrite=1 if Rd==15. Next: FETCH.
//  MEMWR: AdrSrc=1, MemWrite=1, held until the MemReady cycle (inclusive). Next: FETCH on MemReady.
//  EXECR: ALUSrcA=0, ALUSrcB=00, DP decode. Next: ALUWB.
//  EXECI: ALUSrcA=0, ALUSrcB=01, DP decode. Next: ALUWB.
//  ALUWB: ResultSrc=00. RegWrite=1 unless cmd is CMP. PCWrite=1 if Rd==15 and cmd is not CMP. Next: FETCH.
//  BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Next: FETCH.
//  DP decode: cmd=funct[4:1] gives the ALU operation:
//    0100 ADD. 0010 SUB. 1010 CMP (uses SUB). 0000 AND. 1100 ORR. Any other cmd uses ADD and writes no flags.
//  Flag update: flags load from ALUFlags on the edge that leaves EXECR/EXECI, only if S=funct[0].
//    ADD, SUB, CMP update all four flags. CMP updates flags even when S=0.
//    AND, ORR update N and Z only; C and V hold.
//  CondEx, by cond: 0000 EQ Z. 0001 NE !Z. 0010 CS C. 0011 CC !C. 0100 MI N. 0101 PL !N.
//    0110 VS V. 0111 VC !V. 1000 HI C&!Z. 1001 LS !C|Z. 1010 GE N==V. 1011 LT N!=V.
//    1100 GT !Z&(N==V). 1101 LE Z|(N!=V). 1110 AL 1. 1111 treated as 1.
//  Latency with MemReady=1: 4 cycles for DP, 3 for branch, 5 for LDR, 4 for STR, 2 for a squashed instruction.
// STRUCTURE
//  Shared package/header arm_ctrl_defs: state encodings, ALUControl codes, cond codes, ResultSrc/ALUSrcB codes.
//  Sub-module cond_logic: holds the NZCV register, partial flag-write enables and the CondEx decode.
//  The remainder is the FSM and the output decode.
// TESTING
//  1. Reset: hold reset 2 cycles, then release with MemReady=1 -> FETCH. IRWrite=PCWrite=1 in the first cycle. Flags=0000.
//  2. ADDS R1,R2,#5 (E29210xx): ALUFlags=0110 in EXECI -> flags=0110, RegWrite=1 in ALUWB, next FETCH on cycle 4.
//  3. BEQ with flags Z=0 -> DECODE goes to FETCH. No PCWrite besides FETCH. Same instruction with Z=1 -> BRANCH, PCWrite=1.
//  4. LDR with MemReady low for 3 cycles in MEMRD -> state holds, no RegWrite. MemReady high -> MEMWB, RegWrite=1.
//  5. STR with MemReady low for 2 cycles -> MemWrite=1 for exactly 3 cycles, then FETCH.
//  6. reset asserted in MEMWR and in ALUWB -> no MemWrite/RegWrite on that edge, flags unchanged, then FETCH.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings and decode helpers for the multicycle ARM-subset controller.
// FSM states, ALU/result/source codes, DP command decode and condition evaluation.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC,
    C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT,
    C_GT, C_LE, C_AL, C_NV
  } cond_e;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_WD  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    alu_ctl_e ctl;
    logic     we_nz;
    logic     we_cv;
    logic     is_cmp;
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(
    input logic [3:0] cmd,
    input logic       s
  );
    dp_dec_t d;
    d.ctl    = ALU_ADD;
    d.we_nz  = 1'b0;
    d.we_cv  = 1'b0;
    d.is_cmp = 1'b0;
    case (cmd)
      CMD_ADD: begin
        d.we_nz = s;
        d.we_cv = s;
      end
      CMD_SUB: begin
        d.ctl   = ALU_SUB;
        d.we_nz = s;
        d.we_cv = s;
      end
      // CMP exists only to set flags, so S is implied
      CMD_CMP: begin
        d.ctl    = ALU_SUB;
        d.we_nz  = 1'b1;
        d.we_cv  = 1'b1;
        d.is_cmp = 1'b1;
      end
      CMD_AND: begin
        d.ctl   = ALU_AND;
        d.we_nz = s;
      end
      CMD_ORR: begin
        d.ctl   = ALU_ORR;
        d.we_nz = s;
      end
      default: d.ctl = ALU_ADD;
    endcase
    return d;
  endfunction

  function automatic logic cond_eval(
    input logic [3:0] cond,
    input logic [3:0] f
  );
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond_e'(cond))
      C_EQ:    r = z;
      C_NE:    r = !z;
      C_CS:    r = c;
      C_CC:    r = !c;
      C_MI:    r = n;
      C_PL:    r = !n;
      C_VS:    r = v;
      C_VC:    r = !v;
      C_HI:    r = c & !z;
      C_LS:    r = !c | z;
      C_GE:    r = (n == v);
      C_LT:    r = (n != v);
      C_GT:    r = !z & (n == v);
      C_LE:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// master: the controller side; slave: the datapath side.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic        Undef;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output ResultSrc, ALUSrcA, ALUSrcB,
    output ALUControl, ImmSrc, RegSrc,
    output RegWrite, Undef
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB,
    input  ALUControl, ImmSrc, RegSrc,
    input  RegWrite, Undef
  );
endinterface

// File: rtl/mc_controller_cond_logic.sv
// NZCV flag register with split N/Z and C/V write enables.
// Produces CondEx for the instruction's condition field from the held flags.
module mc_controller_cond_logic
  import mc_controller_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       we_nz_i,
  input  logic       we_cv_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAGS_RESET;
    end else begin
      if (we_nz_i) flags_q[3:2] <= alu_flags_i[3:2];
      if (we_cv_i) flags_q[1:0] <= alu_flags_i[1:0];
    end
  end

  assign cond_ex_o = cond_eval(cond_i, flags_q);

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/writeback.
// Outputs decode from the state and the instruction latched at DECODE.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_e      state_q, state_d;
  logic [19:0] instr_q;
  logic [19:0] ins;
  logic        mem_rdy;
  logic        cond_ex;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        rd_pc;
  dp_dec_t     dp;
  logic        in_exec;
  logic        unused;

  assign mem_rdy = MEM_WAIT_EN ? bus.MemReady : 1'b1;

  // IR is fresh in DECODE; later states use our own copy
  assign ins   = (state_q == S_DECODE) ? bus.Instr : instr_q;
  assign op    = ins[15:14];
  assign funct = ins[13:8];
  assign rd_pc = (ins[3:0] == 4'hF);
  assign dp    = dp_decode(funct[4:1], funct[0]);
  assign unused = ^ins[7:4];

  assign in_exec = (state_q == S_EXECR) ||
                   (state_q == S_EXECI);

  mc_controller_cond_logic #(
    .FLAGS_RESET (FLAGS_RESET)
  ) u_cond_logic (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (ins[19:16]),
    .alu_flags_i (bus.ALUFlags),
    .we_nz_i     (in_exec && dp.we_nz),
    .we_cv_i     (in_exec && dp.we_cv),
    .cond_ex_o   (cond_ex)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else begin
          unique case (op)
            OP_DP:  state_d = funct[5] ? S_EXECI
                                       : S_EXECR;
            OP_MEM: state_d = S_MEMADR;
            OP_BR:  state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD
                                   : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) instr_q <= bus.Instr;
    end
  end

  logic       pcw, adr, mw, irw, rw, und, srca;
  logic [1:0] res, srcb;
  alu_ctl_e   alu;

  always_comb begin
    pcw  = 1'b0;
    adr  = 1'b0;
    mw   = 1'b0;
    irw  = 1'b0;
    rw   = 1'b0;
    und  = 1'b0;
    srca = 1'b0;
    res  = RES_ALUOUT;
    srcb = SRCB_WD;
    alu  = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        srca = 1'b1;
        srcb = SRCB_4;
        res  = RES_ALURES;
        irw  = mem_rdy;
        pcw  = mem_rdy;
      end
      S_DECODE: begin
        srca = 1'b1;
        srcb = SRCB_4;
        res  = RES_ALURES;
        und  = cond_ex && (op == OP_UNDEF);
      end
      S_MEMADR: srcb = SRCB_IMM;
      S_MEMRD:  adr  = 1'b1;
      S_MEMWB: begin
        res = RES_DATA;
        rw  = 1'b1;
        pcw = rd_pc;
      end
      S_MEMWR: begin
        adr = 1'b1;
        mw  = 1'b1;
      end
      S_EXECR:  alu = dp.ctl;
      S_EXECI: begin
        srcb = SRCB_IMM;
        alu  = dp.ctl;
      end
      S_ALUWB: begin
        alu = dp.ctl;
        rw  = !dp.is_cmp;
        pcw = rd_pc && !dp.is_cmp;
      end
      S_BRANCH: begin
        srcb = SRCB_IMM;
        res  = RES_ALURES;
        pcw  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite    = pcw & ~reset;
  assign bus.MemWrite   = mw  & ~reset;
  assign bus.IRWrite    = irw & ~reset;
  assign bus.RegWrite   = rw  & ~reset;
  assign bus.Undef      = und & ~reset;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = res;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ALUControl = alu;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller.
// An instruction-level model queues per-cycle expected controls; a monitor checks them.
module tb_mc_controller;

  localparam logic [3:0] FRST = 4'b0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();

  mc_controller #(
    .FLAGS_RESET (FRST),
    .MEM_WAIT_EN (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [16:0] v;
    logic [16:0] m;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mflags;
  int         cyc_in_instr;
  int         abort_at;
  bit         aborted;

  function automatic logic [16:0] ov(
    input logic pcw, adr, mw, irw,
    input logic [1:0] res,
    input logic sa,
    input logic [1:0] sb, alu, imm, rs,
    input logic rw, und
  );
    return {pcw, adr, mw, irw, res, sa, sb,
            alu, imm, rs, rw, und};
  endfunction

  function automatic logic [16:0] mk(
    input logic adr, res, sa, sb, alu, imm
  );
    return ov(1'b1, adr, 1'b1, 1'b1, {2{res}}, sa,
              {2{sb}}, {2{alu}}, {2{imm}}, {2{imm}},
              1'b1, 1'b1);
  endfunction

  function automatic logic cx(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic step(
    input logic [16:0] v,
    input logic [16:0] m,
    input logic        mr,
    input logic [3:0]  af
  );
    exp_t e;
    if (aborted) return;
    cyc_in_instr++;
    bus.MemReady = mr;
    bus.ALUFlags = af;
    if (cyc_in_instr == abort_at) begin
      aborted = 1'b1;
      reset   = 1'b1;
      e.v = '0;
      e.m = mk(0, 0, 0, 0, 0, 0);
    end else begin
      reset = 1'b0;
      e.v = v;
      e.m = m;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(
    input logic [19:0] ins,
    input int          fw,
    input int          mw,
    input logic [3:0]  af,
    input int          ab
  );
    logic [1:0] op, rs, alu;
    logic [5:0] fn;
    logic       c, und, rd15, nz, cv, cmp;
    aborted      = 1'b0;
    cyc_in_instr = 0;
    abort_at     = ab;
    op   = ins[15:14];
    fn   = ins[13:8];
    rd15 = (ins[3:0] == 4'hF);
    rs   = {op == 2'b01, op == 2'b10};
    for (int i = 0; i < fw; i++)
      step(ov(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00,
              0, 0, 0, 0),
           mk(1, 1, 1, 1, 1, 0), 1'b0, r4());
    step(ov(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00,
            0, 0, 0, 0),
         mk(1, 1, 1, 1, 1, 0), 1'b1, r4());
    if (aborted) begin
      mflags = FRST;
      return;
    end
    bus.Instr = ins;
    c   = cx(ins[19:16], mflags);
    und = c && (op == 2'b11);
    step(ov(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00,
            op, rs, 0, und),
         mk(0, 1, 1, 1, 0, 1), r1(), r4());
    if (c && op == 2'b00) begin
      nz = 1'b0; cv = 1'b0; cmp = 1'b0;
      case (fn[4:1])
        4'b0100: begin alu = 2'd0; nz = fn[0]; cv = fn[0]; end
        4'b0010: begin alu = 2'd1; nz = fn[0]; cv = fn[0]; end
        4'b1010: begin alu = 2'd1; nz = 1; cv = 1; cmp = 1; end
        4'b0000: begin alu = 2'd2; nz = fn[0]; end
        4'b1100: begin alu = 2'd3; nz = fn[0]; end
        default: alu = 2'd0;
      endcase
      step(ov(0, 0, 0, 0, 2'b00, 0,
              fn[5] ? 2'b01 : 2'b00, alu, op, rs, 0, 0),
           mk(0, 0, 1, 1, 1, 1), r1(), af);
      if (!aborted) begin
        if (nz) mflags[3:2] = af[3:2];
        if (cv) mflags[1:0] = af[1:0];
      end
      step(ov(rd15 && !cmp, 0, 0, 0, 2'b00, 0, 2'b00,
              2'b00, op, rs, !cmp, 0),
           mk(0, 1, 0, 0, 0, 1), r1(), r4());
    end else if (c && op == 2'b01) begin
      step(ov(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00,
              op, rs, 0, 0),
           mk(0, 0, 1, 1, 1, 1), r1(), r4());
      for (int i = 0; i <= mw; i++)
        step(ov(0, 1, !fn[0], 0, 2'b00, 0, 2'b00,
                2'b00, op, rs, 0, 0),
             mk(1, 0, 0, 0, 0, 1), i == mw, r4());
      if (fn[0])
        step(ov(rd15, 0, 0, 0, 2'b01, 0, 2'b00,
                2'b00, op, rs, 1, 0),
             mk(0, 1, 0, 0, 0, 1), r1(), r4());
    end else if (c && op == 2'b10) begin
      step(ov(1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00,
              op, rs, 0, 0),
           mk(0, 1, 1, 1, 1, 1), r1(), r4());
    end
    if (aborted) mflags = FRST;
  endtask

  exp_t        mon_e;
  logic [16:0] act;

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite,
             bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
             bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
             bus.RegSrc, bus.RegWrite, bus.Undef};
      checks++;
      if ((act & mon_e.m) !== (mon_e.v & mon_e.m)) begin
        errors++;
        $display("FAIL ctrl t=%0t got %b exp %b mask %b",
                 $time, act, mon_e.v, mon_e.m);
      end
    end
  end

  initial begin
    logic [19:0] ins;
    int          ab;
    reset        = 1'b1;
    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'h0;
    bus.MemReady = 1'b1;
    mflags       = FRST;
    aborted      = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.v = '0;
      e.m = mk(0, 0, 0, 0, 0, 0);
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
    run_instr(20'hE2921, 0, 0, 4'b0110, 0);
    run_instr(20'h0A000, 0, 0, 4'b0000, 0);
    run_instr(20'hE3510, 1, 0, 4'b0000, 0);
    run_instr(20'h0A000, 0, 0, 4'b0000, 0);
    run_instr(20'hE5912, 0, 3, 4'b0000, 0);
    run_instr(20'hE5812, 0, 2, 4'b0000, 0);
    run_instr(20'hE5812, 0, 2, 4'b0000, 4);
    run_instr(20'hE2921, 0, 0, 4'b0100, 4);
    run_instr(20'h0A000, 0, 0, 4'b0000, 0);
    run_instr(20'h1A000, 0, 0, 4'b0000, 0);
    run_instr(20'hE081F, 0, 0, 4'b1001, 0);
    run_instr(20'hE7000, 0, 0, 4'b0000, 0);
    for (int n = 0; n < 500; n++) begin
      ins = 20'($urandom);
      if (r1()) ins[19:16] = 4'hE;
      ab = ($urandom_range(9, 0) == 0)
           ? $urandom_range(7, 1) : 0;
      run_instr(ins, $urandom_range(2, 0),
                $urandom_range(3, 0), r4(), ab);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left %0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
